// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: parity modes,
// FSM state encodings and the parity helper used by both TX and RX.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Widest legal payload; narrower payloads are zero-extended before parity.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_core_param_bit_timer.sv
// Loadable down-counter for UART bit timing. Loading value N makes the tick
// appear N cycles later, so a bit lasting B cycles is loaded with B-1.
module uart_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // Holds at zero once the terminal count is reached; never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_core_param.sv
// Single-clock UART core: ready/valid transmitter with registered serial
// output, and a mid-bit-sampling receiver with parity/frame/overrun flags.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  input  logic                 rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TW   = $clog2(CLK_DIV);
  localparam int IW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLK_DIV / 2;
  localparam logic [TW-1:0] T_FULL    = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_HALF    = TW'(HALF - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != PAR_NONE);

  tx_state_t            r_tx_state, w_tx_state_next;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [IW-1:0]        r_tx_idx;
  logic                 r_tx_par, r_tx, w_tx_next, w_tx_load, w_tx_tick, w_tx_done;

  uart_bit_timer #(.W(TW)) u_tx_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tx_load),
    .i_load_val (T_FULL),
    .o_tick     (w_tx_tick)
  );

  // w_tx_next is the line level for the coming cycle, so tx is glitch-free.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_load       = 1'b0;
    w_tx_done       = 1'b0;
    w_tx_next       = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          w_tx_state_next = TX_START;
          w_tx_load       = 1'b1;
          w_tx_next       = 1'b0;
        end
      end
      TX_START: begin
        w_tx_next = 1'b0;
        if (w_tx_tick) begin
          w_tx_state_next = TX_DATA;
          w_tx_load       = 1'b1;
          w_tx_next       = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        w_tx_next = r_tx_shift[0];
        if (w_tx_tick) begin
          w_tx_load = 1'b1;
          if (r_tx_idx == LAST_DATA) begin
            w_tx_state_next = HAS_PAR ? TX_PARITY : TX_STOP;
            w_tx_next       = HAS_PAR ? r_tx_par : 1'b1;
          end else begin
            w_tx_next = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        w_tx_next = r_tx_par;
        if (w_tx_tick) begin
          w_tx_state_next = TX_STOP;
          w_tx_load       = 1'b1;
        end
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          if (r_tx_idx == LAST_STOP) begin
            w_tx_state_next = TX_IDLE;
            w_tx_done       = 1'b1;
          end else begin
            w_tx_load = 1'b1;
          end
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx       <= w_tx_next;
      if (r_tx_state == TX_IDLE && tx_valid) begin
        r_tx_shift <= tx_data;
        r_tx_par   <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
        r_tx_idx   <= '0;
      end else if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_idx   <= (r_tx_idx == LAST_DATA) ? '0 : r_tx_idx + 1'b1;
      end else if (r_tx_state == TX_STOP && w_tx_tick && r_tx_idx != LAST_STOP) begin
        r_tx_idx <= r_tx_idx + 1'b1;
      end
    end
  end

  assign tx       = r_tx;
  assign tx_ready = (r_tx_state == TX_IDLE);
  assign tx_done  = w_tx_done;

  rx_state_t            r_rx_state, w_rx_state_next;
  logic                 r_rx_meta, r_rx_s, r_rx_armed, r_rx_par_bit;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
  logic [IW-1:0]        r_rx_idx;
  logic                 r_rx_valid, r_rx_parity_err, r_rx_frame_err, r_rx_overrun;
  logic                 w_rx_load, w_rx_tick, w_rx_done;
  logic [TW-1:0]        w_rx_load_val;

  uart_bit_timer #(.W(TW)) u_rx_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .o_tick     (w_rx_tick)
  );

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_load       = 1'b0;
    w_rx_load_val   = T_FULL;
    w_rx_done       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_armed && !r_rx_s) begin
          w_rx_state_next = RX_START;
          w_rx_load       = 1'b1;
          w_rx_load_val   = T_HALF;
        end
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (w_rx_tick) begin
          if (r_rx_s) begin
            w_rx_state_next = RX_IDLE;
          end else begin
            w_rx_state_next = RX_DATA;
            w_rx_load       = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_load = 1'b1;
          if (r_rx_idx == LAST_DATA) begin
            w_rx_state_next = HAS_PAR ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_tick) begin
          w_rx_state_next = RX_STOP;
          w_rx_load       = 1'b1;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_state_next = RX_IDLE;
          w_rx_done       = 1'b1;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_rx_state      <= RX_IDLE;
      r_rx_shift      <= '0;
      r_rx_idx        <= '0;
      r_rx_par_bit    <= 1'b0;
      r_rx_armed      <= 1'b1;
      r_rx_valid      <= 1'b0;
      r_rx_data       <= '0;
      r_rx_parity_err <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_overrun    <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_s       <= r_rx_meta;
      r_rx_state   <= w_rx_state_next;
      r_rx_overrun <= 1'b0;
      if (r_rx_state == RX_IDLE) begin
        r_rx_idx <= '0;
      end else if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
        r_rx_idx   <= (r_rx_idx == LAST_DATA) ? '0 : r_rx_idx + 1'b1;
      end
      if (r_rx_state == RX_PARITY && w_rx_tick) begin
        r_rx_par_bit <= r_rx_s;
      end
      // A line held low through the stop bit (break) must go high before re-arming.
      if (w_rx_done && !r_rx_s) begin
        r_rx_armed <= 1'b0;
      end else if (r_rx_s) begin
        r_rx_armed <= 1'b1;
      end
      if (w_rx_done) begin
        r_rx_valid      <= 1'b1;
        r_rx_data       <= r_rx_shift;
        r_rx_parity_err <= HAS_PAR && (r_rx_par_bit != parity_bit(MAX_DATA_BITS'(r_rx_shift), PARITY));
        r_rx_frame_err  <= ~r_rx_s;
        r_rx_overrun    <= r_rx_valid && !rx_ready;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_parity_err = r_rx_parity_err;
  assign rx_frame_err  = r_rx_frame_err;
  assign rx_overrun    = r_rx_overrun;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench: three cores (8N1, 8E1, 8N2 at CLK_DIV=16), each with a
// selectable loopback or bench-driven rx line.
module tb_uart_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] tx_valid, tx_ready, tx_o, tx_done, rx_i, rx_valid, rx_ready;
  logic [2:0] rx_parity_err, rx_frame_err, rx_overrun, lb, rx_drv;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];

  assign rx_i[0] = lb[0] ? tx_o[0] : rx_drv[0];
  assign rx_i[1] = lb[1] ? tx_o[1] : rx_drv[1];
  assign rx_i[2] = lb[2] ? tx_o[2] : rx_drv[2];

  uart_core_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(16)) u_dut0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
    .tx(tx_o[0]), .tx_done(tx_done[0]), .rx(rx_i[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .rx_data(rx_data[0]), .rx_parity_err(rx_parity_err[0]), .rx_frame_err(rx_frame_err[0]),
    .rx_overrun(rx_overrun[0]));

  uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(16)) u_dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
    .tx(tx_o[1]), .tx_done(tx_done[1]), .rx(rx_i[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .rx_data(rx_data[1]), .rx_parity_err(rx_parity_err[1]), .rx_frame_err(rx_frame_err[1]),
    .rx_overrun(rx_overrun[1]));

  uart_core_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .CLK_DIV(16)) u_dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
    .tx(tx_o[2]), .tx_done(tx_done[2]), .rx(rx_i[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .rx_data(rx_data[2]), .rx_parity_err(rx_parity_err[2]), .rx_frame_err(rx_frame_err[2]),
    .rx_overrun(rx_overrun[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Sends one byte; returns the tx_done offset from accept and the mid-bit tx samples per slot.
  task automatic tx_frame(input int d, input logic [7:0] b, output int done_k, output logic [11:0] slots);
    check("tx_ready_before", tx_ready[d], 1);
    tx_valid[d] = 1'b1;
    tx_data[d]  = b;
    @(negedge clk);
    tx_valid[d] = 1'b0;
    check("tx_start_low", tx_o[d], 0);
    done_k = -1;
    slots  = '0;
    for (int k = 1; k <= 400; k++) begin
      if (k % 16 == 8 && k / 16 < 12) slots[k/16] = tx_o[d];
      if (tx_done[d]) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check("tx_ready_after", tx_ready[d], 1);
  endtask

  task automatic wait_rx(input int d, output int ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (rx_valid[d]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume(input int d);
    rx_ready[d] = 1'b1;
    @(negedge clk);
    rx_ready[d] = 1'b0;
    check("rx_consume_clears", rx_valid[d], 0);
  endtask

  // Drives n bit-times LSB first on the bench rx line, counting overrun pulses.
  task automatic drive_frame(input int d, input logic [15:0] bits, input int n, output int ovr);
    ovr = 0;
    for (int i = 0; i < n; i++) begin
      rx_drv[d] = bits[i];
      repeat (16) begin
        @(negedge clk);
        if (rx_overrun[d]) ovr++;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, ok, ovr, seen;
    logic [11:0] s;
    rst = 1'b1;
    tx_valid = '0; rx_ready = '0; lb = 3'b111; rx_drv = 3'b111;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_o[0], 1);
    check("rst_tx_ready", tx_ready[0], 1);
    check("rst_rx_data", rx_data[0], 0);
    check("rst_flags", {rx_valid[0], rx_parity_err[0], rx_frame_err[0], rx_overrun[0], tx_done[0]}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 loopback of 0xA5
    tx_frame(0, 8'hA5, k, s);
    check("t1_done_cycle", k, 160);
    check("t1_tx_bits", s, {1'b1, 8'hA5, 1'b0});
    wait_rx(0, ok);
    check("t1_rx_valid", ok, 1);
    check("t1_rx_data", rx_data[0], 8'hA5);
    check("t1_rx_errs", {rx_parity_err[0], rx_frame_err[0], rx_overrun[0]}, 0);
    consume(0);

    // 8E1 loopback of 0x01, then a frame with a wrong parity bit
    tx_frame(1, 8'h01, k, s);
    check("t2_done_cycle", k, 176);
    check("t2_tx_bits", s, {1'b1, 1'b1, 8'h01, 1'b0});
    wait_rx(1, ok);
    check("t2_rx_valid", ok, 1);
    check("t2_rx_data", rx_data[1], 8'h01);
    check("t2_rx_par_ok", rx_parity_err[1], 0);
    consume(1);
    lb[1] = 1'b0;
    repeat (2) @(negedge clk);
    drive_frame(1, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, ovr);
    wait_rx(1, ok);
    check("t2b_rx_valid", ok, 1);
    check("t2b_rx_data", rx_data[1], 8'h01);
    check("t2b_par_err", rx_parity_err[1], 1);
    check("t2b_frame_err", rx_frame_err[1], 0);
    consume(1);

    // Frame error with stop bit low, then a held break
    lb[0] = 1'b0;
    repeat (2) @(negedge clk);
    drive_frame(0, {6'b0, 1'b0, 8'h5A, 1'b0}, 10, ovr);
    wait_rx(0, ok);
    check("t3_rx_valid", ok, 1);
    check("t3_rx_data", rx_data[0], 8'h5A);
    check("t3_frame_err", rx_frame_err[0], 1);
    consume(0);
    seen = 0;
    repeat (48) begin
      @(negedge clk);
      if (rx_valid[0]) seen++;
    end
    check("t3_break_quiet", seen, 0);
    rx_drv[0] = 1'b1;
    repeat (32) @(negedge clk);
    drive_frame(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, ovr);
    wait_rx(0, ok);
    check("t3_next_valid", ok, 1);
    check("t3_next_data", rx_data[0], 8'hC3);
    check("t3_next_errs", {rx_parity_err[0], rx_frame_err[0]}, 0);
    consume(0);

    // Short low glitch must not start a frame
    rx_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv[0] = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (rx_valid[0]) seen++;
    end
    check("t4_glitch_quiet", seen, 0);

    // Overrun: two frames without consuming
    drive_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, ovr);
    wait_rx(0, ok);
    check("t5_first_valid", ok, 1);
    check("t5_first_data", rx_data[0], 8'h11);
    check("t5_first_no_ovr", ovr, 0);
    drive_frame(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, ovr);
    check("t5_ovr_pulses", ovr, 1);
    check("t5_second_data", rx_data[0], 8'h22);
    check("t5_still_valid", rx_valid[0], 1);
    consume(0);

    // Reset during data bit 3 of 0xFF, then a clean 0x3C
    lb[0] = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'hFF;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_tx", tx_o[0], 1);
    check("t6_rst_ready", tx_ready[0], 1);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (rx_valid[0]) seen++;
    end
    check("t6_aborted_quiet", seen, 0);
    tx_frame(0, 8'h3C, k, s);
    check("t6_done_cycle", k, 160);
    check("t6_tx_bits", s, {1'b1, 8'h3C, 1'b0});
    wait_rx(0, ok);
    check("t6_rx_valid", ok, 1);
    check("t6_rx_data", rx_data[0], 8'h3C);
    consume(0);

    // Two stop bits: 176-cycle frame
    tx_frame(2, 8'h3C, k, s);
    check("t7_done_cycle", k, 176);
    check("t7_tx_bits", s, {1'b1, 1'b1, 8'h3C, 1'b0});
    wait_rx(2, ok);
    check("t7_rx_valid", ok, 1);
    check("t7_rx_data", rx_data[2], 8'h3C);
    check("t7_rx_errs", {rx_parity_err[2], rx_frame_err[2]}, 0);
    consume(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
